// File: rtl/generic_bus_sram_responder.sv
// Word SRAM responder for generic_bus_if with programmable wait states.
// Optional access-fault reporting (error port) enabled by `define GEN_BUS_RESP_FAULT_EN.
module generic_bus_sram_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy
`ifdef GEN_BUS_RESP_FAULT_EN
    ,
    output logic        error
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [31:0]     offset;
    logic [AW-1:0]   idx_in, idx_q, sel_idx;
    logic            fault_in, fault_q, sel_fault;
    logic            wr_q, sel_wr;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            enter_done;

    assign req    = ren | wen;
    assign offset = addr - BASE_ADDR;
    assign idx_in = offset[AW+1:2];

`ifdef GEN_BUS_RESP_FAULT_EN
    // Any offset beyond the array (including a wrapped negative one) faults.
    assign fault_in = |offset[31:AW+2];
    logic unused_bits;
    assign unused_bits = ^offset[1:0];
`else
    assign fault_in = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{offset[1:0], offset[31:AW+2]};
`endif

    // Entry to DONE straight from IDLE (LATENCY=0) must use the live request.
    assign sel_idx   = (state == IDLE) ? idx_in   : idx_q;
    assign sel_fault = (state == IDLE) ? fault_in : fault_q;
    assign sel_wr    = (state == IDLE) ? wen      : wr_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req) state_n = (LATENCY == 0) ? DONE : WAIT;
            WAIT: begin
                if (!req)              state_n = IDLE;
                else if (cnt == 4'd1)  state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy       = req && (state != DONE);
    assign enter_done = (state_n == DONE) && (state != DONE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            idx_q   <= '0;
            fault_q <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                idx_q   <= idx_in;
                fault_q <= fault_in;
                wr_q    <= wen;
                wdata_q <= wdata;
                be_q    <= byte_en;
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_done) begin
                if (sel_fault)    rdata <= 32'hBAD1_BAD1;
                else if (!sel_wr) rdata <= mem[sel_idx];
            end
        end
    end

`ifdef GEN_BUS_RESP_FAULT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) error <= 1'b0;
        else       error <= enter_done && sel_fault;
    end
`endif

    // Memory is not reset; reset forces state away from DONE so no commit occurs.
    always_ff @(posedge CLK) begin
        if (state == DONE && wr_q && !fault_q) begin
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Directed bench: table of bus accesses on a LATENCY=2 instance plus corner sequences
// (abort, reset mid-access, address change) and a LATENCY=0 back-to-back stream.
module tb_generic_bus_sram_responder;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ren = 1'b0, wen = 1'b0, busy;
    logic [3:0]  byte_en = 4'hF;
    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic        ren0 = 1'b0, wen0 = 1'b0, busy0;
    logic [3:0]  be0 = 4'hF;
`ifdef GEN_BUS_RESP_FAULT_EN
    logic        err2, err0, last_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    generic_bus_sram_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u2 (
        .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
        .byte_en(byte_en), .rdata(rdata), .busy(busy)
`ifdef GEN_BUS_RESP_FAULT_EN
        , .error(err2)
`endif
    );

    generic_bus_sram_responder #(.DEPTH(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u0 (
        .CLK(CLK), .nRST(nRST), .addr(addr0), .wdata(wdata0), .ren(ren0), .wen(wen0),
        .byte_en(be0), .rdata(rdata0), .busy(busy0)
`ifdef GEN_BUS_RESP_FAULT_EN
        , .error(err0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // op: 0 read, 1 write, 2 read+write. lat = cycle (from acceptance) where busy drops.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int chg_k, input logic [31:0] chg_a,
                          output int lat, output logic [31:0] rd);
        @(posedge CLK); #1;
        addr = a; wdata = d; byte_en = be;
        ren = (op != 1); wen = (op != 0);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (!busy) begin lat = k; break; end
            if (k == chg_k) addr = chg_a;
        end
        rd = rdata;
`ifdef GEN_BUS_RESP_FAULT_EN
        last_err = err2;
`endif
        @(posedge CLK); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          op;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [31:0] rd;

        vt[0]  = '{"wr10",     1, 32'h10,   32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{"rd10",     0, 32'h10,   32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF};
        vt[2]  = '{"wr20",     1, 32'h20,   32'h1122_3344, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{"wr20_be5", 1, 32'h20,   32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
        vt[4]  = '{"rd20",     0, 32'h20,   32'h0,         4'hF, 1'b1, 32'h11BB_33DD};
        vt[5]  = '{"wr24",     1, 32'h24,   32'h0102_0304, 4'hF, 1'b0, 32'h0};
        vt[6]  = '{"wr24_be0", 1, 32'h24,   32'hCAFE_F00D, 4'h0, 1'b0, 32'h0};
        vt[7]  = '{"rd24",     0, 32'h24,   32'h0,         4'hF, 1'b1, 32'h0102_0304};
        vt[8]  = '{"rw30",     2, 32'h30,   32'h5,         4'hF, 1'b1, 32'h0102_0304};
        vt[9]  = '{"rd30",     0, 32'h30,   32'h0,         4'hF, 1'b1, 32'h5};
        vt[10] = '{"wr0",      1, 32'h0,    32'h1357_9BDF, 4'hF, 1'b0, 32'h0};
        vt[11] = '{"wr1000",   1, 32'h1000, 32'h2468_ACE0, 4'hF, 1'b0, 32'h0};
`ifdef GEN_BUS_RESP_FAULT_EN
        vt[12] = '{"rd0",      0, 32'h0,    32'h0,         4'hF, 1'b1, 32'h1357_9BDF};
        vt[13] = '{"rd1000",   0, 32'h1000, 32'h0,         4'hF, 1'b1, 32'hBAD1_BAD1};
`else
        vt[12] = '{"rd0",      0, 32'h0,    32'h0,         4'hF, 1'b1, 32'h2468_ACE0};
        vt[13] = '{"rd1000",   0, 32'h1000, 32'h0,         4'hF, 1'b1, 32'h2468_ACE0};
`endif

        // Reset state
        #3;
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy_idle", {31'b0, busy}, 32'h0);
        ren = 1'b1; #1;
        check("rst_busy_req", {31'b0, busy}, 32'h1);
        ren = 1'b0;
        check("rst_rdata0", rdata0, 32'h0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            access(vt[i].op, vt[i].a, vt[i].d, vt[i].be, -1, 32'h0, lat, rd);
            check({vt[i].name, "_lat"}, 32'(lat), 32'd3);
            if (vt[i].chk) check({vt[i].name, "_rdata"}, rd, vt[i].exp);
`ifdef GEN_BUS_RESP_FAULT_EN
            check({vt[i].name, "_err"}, {31'b0, last_err}, {31'b0, vt[i].a >= 32'h1000});
`endif
        end
        @(negedge CLK);
        check("idle_busy", {31'b0, busy}, 32'h0);

        // Request dropped during WAIT aborts without committing the write
        access(1, 32'h40, 32'h7777_7777, 4'hF, -1, 32'h0, lat, rd);
        @(posedge CLK); #1;
        addr = 32'h40; wdata = 32'h8888_8888; wen = 1'b1;
        @(posedge CLK); #1;
        wen = 1'b0;
        @(negedge CLK);
        check("abort_busy", {31'b0, busy}, 32'h0);
        access(0, 32'h40, 32'h0, 4'hF, -1, 32'h0, lat, rd);
        check("abort_lat", 32'(lat), 32'd3);
        check("abort_rdata", rd, 32'h7777_7777);

        // Address change in WAIT is ignored
        access(0, 32'h10, 32'h0, 4'hF, 1, 32'h20, lat, rd);
        check("addrchg_lat", 32'(lat), 32'd3);
        check("addrchg_rdata", rd, 32'hDEAD_BEEF);

        // Reset in WAIT of a write aborts it and clears rdata
        @(posedge CLK); #1;
        addr = 32'h40; wdata = 32'h9999_9999; wen = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b0; #1;
        check("midrst_rdata", rdata, 32'h0);
        wen = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        access(0, 32'h40, 32'h0, 4'hF, -1, 32'h0, lat, rd);
        check("midrst_lat", 32'(lat), 32'd3);
        check("midrst_rdata40", rd, 32'h7777_7777);

        // LATENCY=0: requests held continuously complete every second cycle
        @(posedge CLK); #1;
        wen0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0 = 32'h100 + 32'(4 * i); wdata0 = 32'hA0A0_0000 + 32'(i);
            @(negedge CLK);
            check("l0_wr_busy_hi", {31'b0, busy0}, 32'h1);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("l0_wr_busy_lo", {31'b0, busy0}, 32'h0);
            @(posedge CLK); #1;
        end
        wen0 = 1'b0; ren0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0 = 32'h100 + 32'(4 * i);
            @(negedge CLK);
            check("l0_rd_busy_hi", {31'b0, busy0}, 32'h1);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("l0_rd_busy_lo", {31'b0, busy0}, 32'h0);
            check("l0_rd_data", rdata0, 32'hA0A0_0000 + 32'(i));
            @(posedge CLK); #1;
        end
        ren0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
